// File: rtl/n64_vinfo_ctrl.sv
// ============================================================================
//  Module      : n64_vinfo_ctrl
//  Description : N64 pixel-bus video-info controller. Tracks the word index
//                inside each 4-word pixel group, extracts nVSYNC/nHSYNC edges
//                from the sync word, counts lines per field and derives the
//                video mode (NTSC/PAL), interlace flag and deblur parameters.
//                All logic runs on the falling edge of nCLK.
//  Options     : N64_VINFO_DEBOUNCE_EN - when defined, n64_480i_o and vmode_o
//                only change after two consecutive locked fields agree on the
//                same new value.
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module n64_vinfo_ctrl (
    input  logic       nCLK,
    input  logic       nRST,
    input  logic       nDSYNC,
    input  logic [3:0] sync_i,
    input  logic       nForceDeBlur_i,
    input  logic       nDeBlurMan_i,
    output logic [1:0] data_cnt_o,
    output logic       n64_480i_o,
    output logic       vmode_o,
    output logic [5:0] deblurparams_o,
    output logic       frame_start_o,
    output logic       vinfo_valid_o
);

    // Sync word bit positions: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
    localparam int         VSYNC_BIT   = 3;
    localparam int         HSYNC_BIT   = 1;

    // Line counter saturation value; reaching it means sync has been lost
    localparam logic [9:0] LINE_MAX    = 10'd1023;

    // Fields longer than this many lines are PAL (312/313), shorter are NTSC
    localparam logic [9:0] PAL_THRESH  = 10'd288;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t     state;

    logic [3:0] sync_q;
    logic [3:0] sync_pre;
    logic       new_word;

    logic [9:0] line_cnt;
    logic [9:0] line_cnt_last;

    logic       nForceDeBlur_q;
    logic       nDeBlurMan_q;

    logic       vs_edge;
    logic       hs_edge;
    logic [9:0] line_cnt_inc;
    logic       sync_lost;
    logic       field_480i;
    logic       field_pal;

`ifdef N64_VINFO_DEBOUNCE_EN
    logic       pend_valid;
    logic       pend_480i;
    logic       pend_vmode;
`endif

    // nCLAMP/nCSYNC travel with the sync word but play no part in this block
    logic       unused_sync_bits;
    assign unused_sync_bits = &{1'b0, sync_q[2], sync_q[0], sync_pre[2], sync_pre[0]};

    // Edges are qualified by new_word so each sync word is evaluated once,
    // in the cycle right after it was captured.
    assign vs_edge   = new_word & sync_pre[VSYNC_BIT] & ~sync_q[VSYNC_BIT];
    assign hs_edge   = new_word & sync_pre[HSYNC_BIT] & ~sync_q[HSYNC_BIT];

    // Line count including a same-word nHSYNC edge, so a coincident edge is
    // counted before the field length is captured.
    assign line_cnt_inc = (hs_edge && (line_cnt != LINE_MAX)) ? (line_cnt + 10'd1)
                                                              : line_cnt;

    assign sync_lost  = (line_cnt == LINE_MAX);

    // Interlace shows up as alternating odd/even field lengths
    assign field_480i = line_cnt_inc[0] ^ line_cnt_last[0];
    assign field_pal  = (line_cnt_inc > PAL_THRESH);

    assign deblurparams_o = {data_cnt_o, n64_480i_o, vmode_o, nForceDeBlur_q, nDeBlurMan_q};

    // Word index within the pixel group: nDSYNC realigns, otherwise free-run mod 4
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            data_cnt_o <= 2'b00;
        end else if (!nDSYNC) begin
            data_cnt_o <= 2'b00;
        end else begin
            data_cnt_o <= data_cnt_o + 2'b01;
        end
    end

    // Capture the sync word and keep the previous one for edge detection
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            sync_q   <= 4'hF;
            sync_pre <= 4'hF;
            new_word <= 1'b0;
        end else begin
            new_word <= ~nDSYNC;
            if (!nDSYNC) begin
                sync_pre <= sync_q;
                sync_q   <= sync_i;
            end
        end
    end

    // Lines per field: count nHSYNC edges, saturate, restart on each nVSYNC edge
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            line_cnt <= 10'd0;
        end else if (vs_edge) begin
            line_cnt <= 10'd0;
        end else begin
            line_cnt <= line_cnt_inc;
        end
    end

    // Lock FSM with registered status/mode outputs and deblur input latching
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            state          <= ST_INIT;
            line_cnt_last  <= 10'd0;
            n64_480i_o     <= 1'b0;
            vmode_o        <= 1'b0;
            nForceDeBlur_q <= 1'b1;
            nDeBlurMan_q   <= 1'b1;
            frame_start_o  <= 1'b0;
            vinfo_valid_o  <= 1'b0;
`ifdef N64_VINFO_DEBOUNCE_EN
            pend_valid     <= 1'b0;
            pend_480i      <= 1'b0;
            pend_vmode     <= 1'b0;
`endif
        end else begin
            // Field-start strobe and deblur controls follow every nVSYNC edge
            frame_start_o <= vs_edge;
            if (vs_edge) begin
                nForceDeBlur_q <= nForceDeBlur_i;
                nDeBlurMan_q   <= nDeBlurMan_i;
            end

            case (state)
                ST_INIT: begin
                    // First edge only aligns us to a field boundary
                    if (vs_edge) begin
                        state <= ST_MEASURE;
                    end
                    vinfo_valid_o <= 1'b0;
                end

                ST_MEASURE: begin
                    if (sync_lost) begin
                        state         <= ST_INIT;
                        vinfo_valid_o <= 1'b0;
                    end else if (vs_edge) begin
                        // First complete field becomes the reference length
                        state         <= ST_LOCKED;
                        line_cnt_last <= line_cnt_inc;
                        vinfo_valid_o <= 1'b1;
`ifdef N64_VINFO_DEBOUNCE_EN
                        pend_valid    <= 1'b0;
`endif
                    end else begin
                        vinfo_valid_o <= 1'b0;
                    end
                end

                ST_LOCKED: begin
                    if (sync_lost) begin
                        // Mode outputs keep their last values across a sync loss
                        state         <= ST_INIT;
                        vinfo_valid_o <= 1'b0;
`ifdef N64_VINFO_DEBOUNCE_EN
                        pend_valid    <= 1'b0;
`endif
                    end else begin
                        vinfo_valid_o <= 1'b1;
                        if (vs_edge) begin
                            line_cnt_last <= line_cnt_inc;
`ifdef N64_VINFO_DEBOUNCE_EN
                            if ({field_480i, field_pal} == {n64_480i_o, vmode_o}) begin
                                // Field agrees with current outputs: drop any candidate
                                pend_valid <= 1'b0;
                            end else if (pend_valid &&
                                         ({pend_480i, pend_vmode} == {field_480i, field_pal})) begin
                                // Second consecutive field with the same new value
                                n64_480i_o <= field_480i;
                                vmode_o    <= field_pal;
                                pend_valid <= 1'b0;
                            end else begin
                                // New or disagreeing candidate restarts the confirmation
                                pend_480i  <= field_480i;
                                pend_vmode <= field_pal;
                                pend_valid <= 1'b1;
                            end
`else
                            n64_480i_o <= field_480i;
                            vmode_o    <= field_pal;
`endif
                        end
                    end
                end

                default: begin
                    state         <= ST_INIT;
                    vinfo_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_n64_vinfo_ctrl.sv
// ============================================================================
//  Module      : tb_n64_vinfo_ctrl
//  Description : Self-checking bench for n64_vinfo_ctrl. A table of nVSYNC
//                edge events (field length before the edge, deblur inputs,
//                expected outputs) is replayed through a scoreboard queue,
//                plus hand-written sequences for word counting, sync loss
//                and mid-field reset.
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_n64_vinfo_ctrl;

`ifdef N64_VINFO_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    // Sync words {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
    localparam logic [3:0] W_IDLE  = 4'hF;
    localparam logic [3:0] W_HS    = 4'hC;
    localparam logic [3:0] W_VS    = 4'h7;
    localparam logic [3:0] W_VS_HS = 4'h4;

    logic       nCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       nDSYNC = 1'b1;
    logic [3:0] sync_i = 4'hF;
    logic       nForceDeBlur_i = 1'b1;
    logic       nDeBlurMan_i = 1'b1;
    logic [1:0] data_cnt_o;
    logic       n64_480i_o;
    logic       vmode_o;
    logic [5:0] deblurparams_o;
    logic       frame_start_o;
    logic       vinfo_valid_o;

    n64_vinfo_ctrl dut (
        .nCLK           (nCLK),
        .nRST           (nRST),
        .nDSYNC         (nDSYNC),
        .sync_i         (sync_i),
        .nForceDeBlur_i (nForceDeBlur_i),
        .nDeBlurMan_i   (nDeBlurMan_i),
        .data_cnt_o     (data_cnt_o),
        .n64_480i_o     (n64_480i_o),
        .vmode_o        (vmode_o),
        .deblurparams_o (deblurparams_o),
        .frame_start_o  (frame_start_o),
        .vinfo_valid_o  (vinfo_valid_o)
    );

    always #5 nCLK = ~nCLK;

    typedef struct {
        int lines_before;
        bit force_in;
        bit man_in;
        bit exp_valid;
        bit exp_i;
        bit exp_v;
    } edge_vec_t;

    edge_vec_t vecs [15];
    edge_vec_t exp_q [$];
    int        dc_q [$];
    int        dc_model = 0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fs_count = 0;

    // Count every frame_start pulse seen (sampled on the inactive edge)
    always @(posedge nCLK) begin
        if (frame_start_o === 1'b1) fs_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic nd, input logic [3:0] s);
        @(posedge nCLK);
        nDSYNC = nd;
        sync_i = s;
    endtask

    // Word-index scoreboard step: compare the previous expectation, then drive
    task automatic dc_step(input logic nd);
        @(posedge nCLK);
        if (dc_q.size() > 0) begin
            int e;
            e = dc_q.pop_front();
            check("data_cnt", {30'd0, data_cnt_o}, e);
        end
        nDSYNC = nd;
        sync_i = W_IDLE;
        dc_model = nd ? ((dc_model + 1) % 4) : 0;
        dc_q.push_back(dc_model);
    endtask

    task automatic dc_drain();
        @(posedge nCLK);
        while (dc_q.size() > 0) begin
            int e;
            e = dc_q.pop_front();
            check("data_cnt", {30'd0, data_cnt_o}, e);
        end
    endtask

    // One line = a plain word then a word carrying the nHSYNC falling edge
    task automatic emit_lines(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, W_IDLE);
            step(1'b1, W_IDLE);
            step(1'b0, W_HS);
            step(1'b1, W_IDLE);
        end
    endtask

    // nVSYNC edge word, output check, then the rest of line 0 (with its hsync)
    task automatic do_edge(input edge_vec_t v, input int idx);
        edge_vec_t e;
        nForceDeBlur_i = v.force_in;
        nDeBlurMan_i   = v.man_in;
        exp_q.push_back(v);
        step(1'b0, W_VS);
        step(1'b1, W_IDLE);
        @(posedge nCLK);
        e = exp_q.pop_front();
        check($sformatf("E%0d frame_start", idx), {31'd0, frame_start_o}, 1);
        check($sformatf("E%0d valid", idx), {31'd0, vinfo_valid_o}, {31'd0, e.exp_valid});
        check($sformatf("E%0d 480i", idx), {31'd0, n64_480i_o}, {31'd0, e.exp_i});
        check($sformatf("E%0d vmode", idx), {31'd0, vmode_o}, {31'd0, e.exp_v});
        check($sformatf("E%0d deblurparams", idx), {26'd0, deblurparams_o},
              {26'd0, 2'b01, e.exp_i, e.exp_v, e.force_in, e.man_in});
        @(posedge nCLK);
        check($sformatf("E%0d frame_start_end", idx), {31'd0, frame_start_o}, 0);
        step(1'b0, W_VS_HS);
        step(1'b1, W_IDLE);
    endtask

    task automatic run_edges(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            emit_lines(vecs[k].lines_before);
            do_edge(vecs[k], k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {lines before edge, nForceDeBlur_i, nDeBlurMan_i, valid, 480i, vmode}
        vecs[0]  = '{49,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};   // INIT -> MEASURE
        vecs[1]  = '{262, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};   // 263 lines, lock
        vecs[2]  = '{262, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};   // 263 vs 263
        vecs[3]  = '{261, 1'b0, 1'b0, 1'b1, !DEB, 1'b0};   // 262 vs 263
        vecs[4]  = '{262, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};   // 263 vs 262
        vecs[5]  = '{261, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};   // 262 vs 263
        vecs[6]  = '{312, 1'b0, 1'b1, 1'b1, 1'b1, !DEB};   // 313 vs 262
        vecs[7]  = '{312, 1'b0, 1'b1, 1'b1, DEB,  !DEB};   // 313 vs 313
        vecs[8]  = '{312, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};   // 313 vs 313
        vecs[9]  = '{262, 1'b0, 1'b1, 1'b1, 1'b0, DEB};    // 263 vs 313
        vecs[10] = '{0,   1'b1, 1'b0, 1'b0, 1'b0, DEB};    // after sync loss
        vecs[11] = '{262, 1'b1, 1'b0, 1'b1, 1'b0, DEB};    // relock, hold
        vecs[12] = '{262, 1'b1, 1'b0, 1'b1, 1'b0, DEB};    // 263 vs 263
        vecs[13] = '{0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};   // after reset
        vecs[14] = '{262, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};   // relock

        // Reset state
        repeat (3) @(posedge nCLK);
        check("reset data_cnt", {30'd0, data_cnt_o}, 0);
        check("reset valid", {31'd0, vinfo_valid_o}, 0);
        check("reset frame_start", {31'd0, frame_start_o}, 0);
        check("reset deblurparams", {26'd0, deblurparams_o}, 6'b000011);
        nRST = 1'b1;

        // Word index: regular groups, a mid-group realign, and a free-running wrap
        dc_step(1'b0); dc_step(1'b1); dc_step(1'b1); dc_step(1'b1);
        dc_step(1'b0); dc_step(1'b1); dc_step(1'b1); dc_step(1'b1);
        dc_step(1'b0); dc_step(1'b1); dc_step(1'b0); dc_step(1'b1);
        dc_step(1'b1); dc_step(1'b1); dc_step(1'b1); dc_step(1'b1);
        dc_drain();

        // Lock, interlace and PAL/NTSC fields
        run_edges(0, 9);

        // Sync loss: no nVSYNC for more than 1023 lines
        emit_lines(1030);
        @(posedge nCLK);
        check("loss valid", {31'd0, vinfo_valid_o}, 0);
        check("loss 480i hold", {31'd0, n64_480i_o}, 0);
        check("loss vmode hold", {31'd0, vmode_o}, {31'd0, DEB});
        check("loss frame_start count", fs_count, 10);

        run_edges(10, 12);

        // Reset pulse mid-field while locked
        emit_lines(100);
        check("pre-reset valid", {31'd0, vinfo_valid_o}, 1);
        @(posedge nCLK);
        nRST = 1'b0;
        nDSYNC = 1'b1;
        sync_i = W_IDLE;
        @(posedge nCLK);
        check("midreset data_cnt", {30'd0, data_cnt_o}, 0);
        check("midreset valid", {31'd0, vinfo_valid_o}, 0);
        check("midreset 480i", {31'd0, n64_480i_o}, 0);
        check("midreset vmode", {31'd0, vmode_o}, 0);
        check("midreset frame_start", {31'd0, frame_start_o}, 0);
        check("midreset deblurparams", {26'd0, deblurparams_o}, 6'b000011);
        nRST = 1'b1;

        run_edges(13, 14);
        @(posedge nCLK);
        check("final frame_start count", fs_count, 15);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
